// File: rtl/wb_write_queue_pkg.sv
// Shared constants and types for the writeback write queue.
// Holds the machine-wide defaults for word length, register address width
// and queue depth, plus the lookup source encoding.
package wb_write_queue_pkg;

    localparam int WBQ_WORD_LEN = 32;
    localparam int WBQ_ADDR_LEN = 5;
    localparam int WBQ_DEPTH    = 4;

    // Where a forwarded value comes from.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_QUEUE  = 2'd1,
        SRC_OUTREG = 2'd2
    } wbq_src_e;

endpackage

// File: rtl/wb_write_queue_fifo.sv
// wbq_fifo: circular storage for pending writeback requests.
// Exposes every slot in age order (index 0 = oldest = head) with a valid
// bit so the parent can run forwarding comparators over all of them.
module wbq_fifo
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH    = WBQ_DEPTH,
    parameter int WORD_LEN = WBQ_WORD_LEN,
    parameter int ADDR_LEN = WBQ_ADDR_LEN,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [ADDR_LEN-1:0]                push_dest,
    input  logic [WORD_LEN-1:0]                push_data,
    input  logic                               pop,
    output logic [CNT_W-1:0]                   count,
    output logic [DEPTH-1:0]                   ent_valid,
    output logic [DEPTH-1:0][ADDR_LEN-1:0]     ent_dest,
    output logic [DEPTH-1:0][WORD_LEN-1:0]     ent_data
);

    logic [ADDR_LEN-1:0] mem_dest [DEPTH];
    logic [WORD_LEN-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    // A push into a full queue is only legal when a pop frees a slot the same edge.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until marked valid by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_dest[wr_ptr] <= push_dest;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Rotate storage into age order starting at the read pointer.
    always_comb begin
        ent_valid = '0;
        ent_dest  = '0;
        ent_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = (CNT_W'(k) < count);
            ent_dest[k]  = mem_dest[PTR_W'(rd_ptr + PTR_W'(k))];
            ent_data[k]  = mem_data[PTR_W'(rd_ptr + PTR_W'(k))];
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: buffers writeback requests and issues one register file
// write per cycle through registered wr_en/wr_dest/wr_val, with
// combinational forwarding of pending values to decode.
// Optional build macro: WBQ_BYPASS_EN -- a request arriving while the queue
// is empty loads the output register directly (1-edge latency).
//
// Handshake: a request transfers on a posedge where in_valid and in_ready
// are both high; in_ready depends only on occupancy and rst, never on
// in_valid or a same-cycle pop. Requests to register 0 transfer and vanish.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH    = WBQ_DEPTH,
    parameter int WORD_LEN = WBQ_WORD_LEN,
    parameter int ADDR_LEN = WBQ_ADDR_LEN,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] in_dest,
    input  logic [WORD_LEN-1:0] in_val,
    output logic                wr_en,
    output logic [ADDR_LEN-1:0] wr_dest,
    output logic [WORD_LEN-1:0] wr_val,
    input  logic [ADDR_LEN-1:0] src1,
    input  logic [ADDR_LEN-1:0] src2,
    output logic                hit1,
    output logic                hit2,
    output logic [WORD_LEN-1:0] fwd1,
    output logic [WORD_LEN-1:0] fwd2,
    output logic [CNT_W-1:0]    count
);

    logic                           accept;
    logic                           live;
    logic                           bypass;
    logic                           push;
    logic                           pop;
    logic [DEPTH-1:0]               ent_valid;
    logic [DEPTH-1:0][ADDR_LEN-1:0] ent_dest;
    logic [DEPTH-1:0][WORD_LEN-1:0] ent_data;
    wbq_src_e                       sel1;
    wbq_src_e                       sel2;
    logic [PTR_W-1:0]               idx1;
    logic [PTR_W-1:0]               idx2;

    assign in_ready = (count != CNT_W'(DEPTH)) && !rst;
    assign accept   = in_valid && in_ready;
    assign live     = accept && (in_dest != '0);
    assign pop      = (count != '0);

`ifdef WBQ_BYPASS_EN
    assign bypass = live && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = live && !bypass;

    wbq_fifo #(
        .DEPTH    (DEPTH),
        .WORD_LEN (WORD_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dest (in_dest),
        .push_data (in_val),
        .pop       (pop),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_dest  (ent_dest),
        .ent_data  (ent_data)
    );

    // Output register: drain the head, or take a bypassed request when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_dest <= '0;
            wr_val  <= '0;
        end else if (pop) begin
            wr_en   <= 1'b1;
            wr_dest <= ent_dest[0];
            wr_val  <= ent_data[0];
        end else if (bypass) begin
            wr_en   <= 1'b1;
            wr_dest <= in_dest;
            wr_val  <= in_val;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Lookup select: output register lowest, later (younger) entries override.
    always_comb begin
        sel1 = SRC_NONE;
        sel2 = SRC_NONE;
        idx1 = '0;
        idx2 = '0;
        if (src1 != '0 && wr_en && wr_dest == src1) sel1 = SRC_OUTREG;
        if (src2 != '0 && wr_en && wr_dest == src2) sel2 = SRC_OUTREG;
        for (int k = 0; k < DEPTH; k++) begin
            if (src1 != '0 && ent_valid[k] && ent_dest[k] == src1) begin
                sel1 = SRC_QUEUE;
                idx1 = PTR_W'(k);
            end
            if (src2 != '0 && ent_valid[k] && ent_dest[k] == src2) begin
                sel2 = SRC_QUEUE;
                idx2 = PTR_W'(k);
            end
        end
    end

    assign hit1 = (sel1 != SRC_NONE);
    assign hit2 = (sel2 != SRC_NONE);
    assign fwd1 = (sel1 == SRC_QUEUE)  ? ent_data[idx1] :
                  (sel1 == SRC_OUTREG) ? wr_val : '0;
    assign fwd2 = (sel2 == SRC_QUEUE)  ? ent_data[idx2] :
                  (sel2 == SRC_OUTREG) ? wr_val : '0;

endmodule

// File: tb/tb_wb_write_queue.sv
// Testbench for wb_write_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model and a write-stream scoreboard.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef WBQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_dest;
    logic [DW-1:0] in_val;
    logic          wr_en;
    logic [AW-1:0] wr_dest;
    logic [DW-1:0] wr_val;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [CW-1:0] count;

    wb_write_queue #(.DEPTH(DEPTH), .WORD_LEN(DW), .ADDR_LEN(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_val   (in_val),
        .wr_en    (wr_en),
        .wr_dest  (wr_dest),
        .wr_val   (wr_val),
        .src1     (src1),
        .src2     (src2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: pending requests in arrival order plus the write port
    logic [AW+DW-1:0] m_q[$];
    logic             m_en;
    logic [AW-1:0]    m_dest;
    logic [DW-1:0]    m_val;
    // scoreboard: every write that must eventually reach the register file
    logic [AW+DW-1:0] exp_q[$];

    function automatic logic [DW:0] model_lookup(input logic [AW-1:0] s);
        if (s == '0) return '0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i][DW +: AW] == s) return {1'b1, m_q[i][DW-1:0]};
        if (m_en && m_dest == s) return {1'b1, m_val};
        return '0;
    endfunction

    // driver: one cycle, inputs applied after negedge, checked, model advanced
    task automatic step(input logic r, input logic v, input logic [AW-1:0] d,
                        input logic [DW-1:0] x, output logic acc);
        logic          m_ready;
        logic [DW:0]   l1;
        logic [DW:0]   l2;
        logic [AW+DW-1:0] item;
        int            sz;
        @(negedge clk);
        rst = r; in_valid = v; in_dest = d; in_val = x;
        #1;
        m_ready = !r && (m_q.size() != DEPTH);
        l1 = model_lookup(src1);
        l2 = model_lookup(src2);
        check("in_ready", in_ready, m_ready);
        check("count",    count,    m_q.size());
        check("wr_en",    wr_en,    m_en);
        check("wr_dest",  wr_dest,  m_dest);
        check("wr_val",   wr_val,   m_val);
        check("hit1",     hit1,     l1[DW]);
        check("fwd1",     fwd1,     l1[DW-1:0]);
        check("hit2",     hit2,     l2[DW]);
        check("fwd2",     fwd2,     l2[DW-1:0]);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) check("sb_spurious_write", wr_en, 1'b0);
            else                   check("sb_write", {wr_dest, wr_val}, exp_q.pop_front());
        end
        acc = v && m_ready;
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_en = 1'b0; m_dest = '0; m_val = '0;
        end else begin
            sz = m_q.size();
            if (sz > 0) begin
                item = m_q.pop_front();
                m_en = 1'b1; m_dest = item[DW +: AW]; m_val = item[DW-1:0];
            end else begin
                m_en = 1'b0;
            end
            if (acc && d != '0) begin
                exp_q.push_back({d, x});
`ifdef WBQ_BYPASS_EN
                if (sz == 0) begin
                    m_en = 1'b1; m_dest = d; m_val = x;
                end else begin
                    m_q.push_back({d, x});
                end
`else
                m_q.push_back({d, x});
`endif
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, acc);
    endtask

    task automatic send(input logic [AW-1:0] d, input logic [DW-1:0] x);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) step(1'b0, 1'b1, d, x, acc);
        if (!acc) check("send_timeout", acc, 1'b1);
    endtask

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_val = '0;
        src1 = '0; src2 = '0;
        m_en = 1'b0; m_dest = '0; m_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_val", wr_val, 0);

        // single write
        src1 = 5'd3;
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, acc);
        idle(LAT - 1);
        #2;
        check("single_wr_en", wr_en, 1);
        check("single_wr_dest", wr_dest, 3);
        check("single_wr_val", wr_val, 32'hDEADBEEF);
        idle(1);
        #2;
        check("single_wr_en_off", wr_en, 0);

        // zero destination
        src1 = 5'd0;
        step(1'b0, 1'b1, 5'd0, 32'h1234, acc);
        #2;
        check("zero_count", count, 0);
        check("zero_wr_en", wr_en, 0);
        check("zero_hit1", hit1, 0);
        idle(2);
        #2;
        check("zero_wr_en_late", wr_en, 0);

        // back-to-back stream with drain running
        for (int i = 1; i <= 5; i++) begin
            send(AW'(i), $urandom);
            #2;
            check("fill_count_le_depth", count <= DEPTH, 1);
        end
        idle(4);
        check("fill_all_written", exp_q.size(), 0);

        // forwarding priority: newest value for the same register wins
        src1 = 5'd7;
        send(5'd7, 32'h11);
        send(5'd7, 32'h22);
        #2;
        check("prio_hit1", hit1, 1);
        check("prio_fwd1", fwd1, 32'h22);
        idle(4);
        #2;
        check("prio_hit1_gone", hit1, 0);
        check("prio_fwd1_gone", fwd1, 0);

        // hit on the output register alone
        src2 = 5'd9;
        send(5'd9, 32'h55);
        idle(LAT - 1);
        #2;
        check("outreg_hit2", hit2, 1);
        check("outreg_fwd2", fwd2, 32'h55);
        idle(2);

        // reset while writes are still pending
        src1 = 5'd11; src2 = 5'd12;
        send(5'd11, 32'hA1);
        send(5'd12, 32'hA2);
        send(5'd11, 32'hA3);
        step(1'b1, 1'b0, '0, '0, acc);
        #2;
        check("rstmid_count", count, 0);
        check("rstmid_wr_en", wr_en, 0);
        check("rstmid_hit1", hit1, 0);
        check("rstmid_hit2", hit2, 0);
        idle(4);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            src1 = AW'($urandom_range(0, 7));
            src2 = AW'($urandom_range(0, 7));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, 7)), $urandom, acc);
        end
        idle(6);
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
